// File: rtl/hazard_pkg.sv
// hazard_pkg: shared latency defaults, timer width and a clog2 helper for the hazard scoreboard
package hazard_pkg;
   localparam int DEF_LOAD_LAT = 1;
   localparam int DEF_ALU_LAT  = 2;
   localparam int TIMER_W      = 3;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/hazard_reg_timer.sv
// hazard_reg_timer: per-register result countdown; busy while the count is nonzero
module hazard_reg_timer
   import hazard_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               dec,
   input  logic [TIMER_W-1:0] value,
   output logic               busy
);
   logic [TIMER_W-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else     cnt <= load ? value : (dec && busy) ? cnt - TIMER_W'(1) : cnt;
   assign busy = cnt != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW/WAW interlock scoreboard with per-register countdown timers.
// Define HAZARD_FORWARD_EN to model ALU forwarding (ALU writers never hold a register busy).
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W    = 4,
   parameter int LOAD_LAT = DEF_LOAD_LAT,
   parameter int ALU_LAT  = DEF_ALU_LAT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_W-1:0]      id_rs,
   input  logic [REG_W-1:0]      id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_W-1:0]      id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  mem_ready,
   input  logic                  flush,
   output logic                  stall_pc,
   output logic                  stall_if_id,
   output logic                  nop,
   output logic [2**REG_W-1:0]   busy_mask,
   output logic [15:0]           stall_count
);
   localparam int NUM_REGS = 2**REG_W;
`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(LOAD_LAT);
   localparam logic [TIMER_W-1:0] ALU_VAL  = FWD ? '0 : TIMER_W'(ALU_LAT);
   logic [NUM_REGS-1:0] busy;
   logic hazard, issue;
   assign busy[0] = 1'b0;
   genvar g;
   for (g = 1; g < NUM_REGS; g++) begin : g_timer
      hazard_reg_timer u_timer (
         .clk   (clk),
         .rst   (rst),
         .load  (issue && id_rd == REG_W'(g)),
         .dec   (mem_ready),
         .value (id_memread ? LOAD_VAL : ALU_VAL),
         .busy  (busy[g])
      );
   end
   assign hazard = ~rst & id_valid & ~flush &
                   ((id_uses_rs & busy[id_rs]) | (id_uses_rt & busy[id_rt]) | (id_regwrite & busy[id_rd]));
   assign issue = id_valid & ~flush & ~hazard & mem_ready & id_regwrite & (id_rd != '0);
   assign stall_pc    = hazard;
   assign stall_if_id = hazard;
   assign nop         = hazard;
   assign busy_mask   = busy;
   always_ff @(posedge clk or posedge rst)
      if (rst)                                   stall_count <= '0;
      else if (hazard && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
endmodule
